dmem_access_arbiter: RTL and testbench
======================================

Name: dmem_access_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported 64-word data memory.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Accepts one request at a time and drives the memory strobes (sig_mem_read / sig_mem_write) for a fixed number of cycles.
- Returns read data or a write acknowledgement, and rejects out-of-range word addresses without touching memory.

Parameters:
- DEPTH, 64: number of 32-bit memory words; valid word addresses are 0..DEPTH-1.
- LATENCY, 1: WAIT cycles between strobe assertion and read-data capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; held high until p0_gnt.
- p0_we  in  1  port 0: 1 = store, 0 = load.
- p0_opcode  in  6  port 0 MIPS opcode: 0x28 = sb, 0x29 = sh, other = word.
- p0_addr  in  32  port 0 word address.
- p0_wdata  in  32  port 0 store data.
- p0_gnt  out  1  port 0 accept pulse.
- p0_rvalid  out  1  port 0 completion pulse.
- p0_rdata  out  32  port 0 load data.
- p0_err  out  1  port 0 address error, valid with p0_rvalid.
- p1_*  same set, same widths and meaning, for port 1.
- mem_address  out  32  memory address.
- mem_write_data  out  32  memory write data.
- mem_opcode  out  6  opcode forwarded to memory for byte/half writes.
- sig_mem_read  out  1  memory read strobe.
- sig_mem_write  out  1  memory write strobe.
- mem_read_data  in  32  memory read data (combinational).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, all outputs 0, priority pointer = port 0.
  - Any in-flight transaction is dropped; no rvalid is issued afterwards.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - With any req high at the clock edge, pick a winner (fixed priority: port 0 wins).
  - Latch the winner's we/opcode/addr/wdata.
  - Winner's gnt goes high for exactly the next cycle. Next state = ACCESS, or RESP if addr >= DEPTH.
  - With no req, stay in IDLE.
- ACCESS (1 cycle):
  - mem_address / mem_write_data / mem_opcode driven from the latched command.
  - Load: sig_mem_read = 1.
  - Store: sig_mem_write = 1 for this single cycle only, so the memory performs a single write per store.
  - Next state = WAIT, counter = LATENCY-1.
- WAIT:
  - Load: sig_mem_read and the address stay held. Store: strobes are 0.
  - Counter decrements each cycle. At 0, a load captures mem_read_data into the response register; next state = RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1. rdata = captured data for a load, 0 for a store.
  - err = 1 only on an address error, with rdata = 0.
  - Next state = IDLE; a new grant is possible the following cycle.
- Timing:
  - Request sampled at edge k gives gnt in cycle k+1 and rvalid in cycle k+2+LATENCY.
  - Address-error path: gnt in cycle k+1, rvalid + err in cycle k+2.
- Requests arriving while busy stay pending; the requester must hold req, and gnt is never issued outside the IDLE->next transition.
- Simultaneous requests: exactly one gnt per transaction. The loser stays pending and is served next.
- The addr >= DEPTH check uses the full 32-bit unsigned compare; a request with address error never asserts either memory strobe.
- Only the owning port's rvalid / rdata / err change. The other port's outputs stay 0.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. The pointer flips to the other port after each grant, so the last-granted port has lowest priority on a simultaneous request. The pointer resets to port 0 priority.
- Undefined: fixed priority, port 0 always wins; the pointer logic is absent.

Test Plan:
- Port 0 store: we=1, opcode 0x2B, addr 5, wdata 0xDEADBEEF, LATENCY=1. Then load addr 5 → p0_rvalid in cycle k+3, p0_rdata = 0xDEADBEEF; sig_mem_write high exactly 1 cycle.
- Port 0 sb: opcode 0x28, addr 5, wdata 0x11 over 0xDEADBEEF, then load → rdata = 0xDEADBE11. Same with sh (0x29), wdata 0x2222 → 0xDEAD2222.
- Out of range: port 1 load addr 64 → p1_gnt, then p1_rvalid = 1, p1_err = 1, rdata = 0 in cycle k+2; sig_mem_read and sig_mem_write never asserted.
- p0_req and p1_req high together for 4 back-to-back transactions:
  - Without DMEM_ARB_RR_EN: all port 0 grants first.
  - With DMEM_ARB_RR_EN: grant order 0,1,0,1.
- rst_n pulsed low during WAIT of a load → all outputs 0 immediately; no rvalid afterwards; the next request completes normally.
- LATENCY=4, load addr 0 → sig_mem_read held 5 cycles, busy high 6 cycles, rvalid in cycle k+6.

Source files
------------

// File: rtl/dmem_access_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (fixed priority, port 0 first, otherwise).
module dmem_access_arbiter #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [5:0]  p0_opcode,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [5:0]  p1_opcode,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [5:0]  mem_opcode,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    state_t      r_state, w_next;
    logic        r_owner, r_we, r_addr_err;
    logic [5:0]  r_opcode;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_cnt;

    logic        r_p0_gnt, r_p0_rvalid, r_p0_err, r_p1_gnt, r_p1_rvalid, r_p1_err;
    logic [31:0] r_p0_rdata, r_p1_rdata, r_mem_address, r_mem_write_data;
    logic [5:0]  r_mem_opcode;
    logic        r_rd, r_wr, r_busy;

    logic        w_req_any, w_pick1, w_sel_we, w_sel_err;
    logic [5:0]  w_sel_opcode;
    logic [31:0] w_sel_addr, w_sel_wdata;
    logic        w_gnt0, w_gnt1, w_rd, w_wr, w_rv, w_err;
    logic [31:0] w_rdata, w_mem_addr, w_mem_wdata;
    logic [5:0]  w_mem_op;

    assign w_req_any = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
    // r_ptr = 1 gives port 1 priority on a simultaneous request
    logic r_ptr;
    assign w_pick1 = p1_req & (~p0_req | r_ptr);

    // Priority pointer: point away from whichever port was just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (r_state == ST_IDLE && w_req_any) begin
            r_ptr <= ~w_pick1;
        end
    end
`else
    assign w_pick1 = p1_req & ~p0_req;
`endif

    assign w_sel_we     = w_pick1 ? p1_we     : p0_we;
    assign w_sel_opcode = w_pick1 ? p1_opcode : p0_opcode;
    assign w_sel_addr   = w_pick1 ? p1_addr   : p0_addr;
    assign w_sel_wdata  = w_pick1 ? p1_wdata  : p0_wdata;
    assign w_sel_err    = (w_sel_addr >= DEPTH_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus next-cycle values of every registered output.
    // An out-of-range command spends its grant cycle in ACCESS with both
    // strobes and the bus quiet, so its response follows the grant directly.
    always_comb begin
        w_next      = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_rv        = 1'b0;
        w_err       = 1'b0;
        w_rdata     = 32'd0;
        w_mem_addr  = 32'd0;
        w_mem_wdata = 32'd0;
        w_mem_op    = 6'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_next      = ST_ACCESS;
                    w_gnt0      = ~w_pick1;
                    w_gnt1      = w_pick1;
                    w_rd        = ~w_sel_err & ~w_sel_we;
                    w_wr        = ~w_sel_err & w_sel_we;
                    w_mem_addr  = w_sel_err ? 32'd0 : w_sel_addr;
                    w_mem_wdata = w_sel_err ? 32'd0 : w_sel_wdata;
                    w_mem_op    = w_sel_err ? 6'd0 : w_sel_opcode;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_addr_err) begin
                    w_next = ST_RESP;
                    w_rv   = 1'b1;
                    w_err  = 1'b1;
                end else begin
                    w_next      = ST_WAIT;
                    w_rd        = ~r_we;
                    w_mem_addr  = r_addr;
                    w_mem_wdata = r_wdata;
                    w_mem_op    = r_opcode;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next  = ST_RESP;
                    w_rv    = 1'b1;
                    w_rdata = r_we ? 32'd0 : mem_read_data;
                end else begin
                    w_rd        = ~r_we;
                    w_mem_addr  = r_addr;
                    w_mem_wdata = r_wdata;
                    w_mem_op    = r_opcode;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Command latch at grant time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_opcode   <= 6'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_addr_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_req_any) begin
            r_owner    <= w_pick1;
            r_we       <= w_sel_we;
            r_opcode   <= w_sel_opcode;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_addr_err <= w_sel_err;
        end
    end

    // WAIT-phase countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == ST_ACCESS) begin
            r_cnt <= LAT_M1;
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Output registers; only the owning port's response fields move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_gnt <= 1'b0;  r_p0_rvalid <= 1'b0;  r_p0_err <= 1'b0;  r_p0_rdata <= 32'd0;
            r_p1_gnt <= 1'b0;  r_p1_rvalid <= 1'b0;  r_p1_err <= 1'b0;  r_p1_rdata <= 32'd0;
            r_mem_address <= 32'd0;  r_mem_write_data <= 32'd0;  r_mem_opcode <= 6'd0;
            r_rd <= 1'b0;  r_wr <= 1'b0;  r_busy <= 1'b0;
        end else begin
            r_p0_gnt         <= w_gnt0;
            r_p1_gnt         <= w_gnt1;
            r_p0_rvalid      <= w_rv & ~r_owner;
            r_p1_rvalid      <= w_rv & r_owner;
            r_p0_err         <= w_err & ~r_owner;
            r_p1_err         <= w_err & r_owner;
            r_p0_rdata       <= (w_rv & ~r_owner) ? w_rdata : 32'd0;
            r_p1_rdata       <= (w_rv & r_owner) ? w_rdata : 32'd0;
            r_mem_address    <= w_mem_addr;
            r_mem_write_data <= w_mem_wdata;
            r_mem_opcode     <= w_mem_op;
            r_rd             <= w_rd;
            r_wr             <= w_wr;
            r_busy           <= (w_next != ST_IDLE);
        end
    end

    assign p0_gnt         = r_p0_gnt;
    assign p0_rvalid      = r_p0_rvalid;
    assign p0_rdata       = r_p0_rdata;
    assign p0_err         = r_p0_err;
    assign p1_gnt         = r_p1_gnt;
    assign p1_rvalid      = r_p1_rvalid;
    assign p1_rdata       = r_p1_rdata;
    assign p1_err         = r_p1_err;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_opcode     = r_mem_opcode;
    assign sig_mem_read   = r_rd;
    assign sig_mem_write  = r_wr;
    assign busy           = r_busy;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter: vector table + scoreboard, plus
// hand-written sequences for simultaneous requests, mid-WAIT reset and LATENCY=4.
module tb_dmem_access_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_clear;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [5:0]  p0_opcode, p1_opcode;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [5:0]  mem_opcode;
    logic        sig_mem_read, sig_mem_write, busy;

    logic        d4_p0_req;
    logic [31:0] d4_p0_addr;
    logic        d4_p0_gnt, d4_p0_rvalid, d4_p0_err, d4_p1_gnt, d4_p1_rvalid, d4_p1_err;
    logic [31:0] d4_p0_rdata, d4_p1_rdata;
    logic [31:0] d4_mem_address, d4_mem_write_data, d4_mem_read_data;
    logic [5:0]  d4_mem_opcode;
    logic        d4_rd, d4_wr, d4_busy;

    always #5 clk = ~clk;

    dmem_access_arbiter #(.DEPTH(64), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_opcode(p0_opcode), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_opcode(p1_opcode), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_opcode(mem_opcode),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    dmem_access_arbiter #(.DEPTH(64), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(d4_p0_req), .p0_we(1'b0), .p0_opcode(6'h23), .p0_addr(d4_p0_addr), .p0_wdata(32'd0),
        .p0_gnt(d4_p0_gnt), .p0_rvalid(d4_p0_rvalid), .p0_rdata(d4_p0_rdata), .p0_err(d4_p0_err),
        .p1_req(1'b0), .p1_we(1'b0), .p1_opcode(6'd0), .p1_addr(32'd0), .p1_wdata(32'd0),
        .p1_gnt(d4_p1_gnt), .p1_rvalid(d4_p1_rvalid), .p1_rdata(d4_p1_rdata), .p1_err(d4_p1_err),
        .mem_address(d4_mem_address), .mem_write_data(d4_mem_write_data), .mem_opcode(d4_mem_opcode),
        .sig_mem_read(d4_rd), .sig_mem_write(d4_wr),
        .mem_read_data(d4_mem_read_data), .busy(d4_busy)
    );

    // Memory model: 64 words, byte/half/word stores, combinational read
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (sig_mem_write) begin
            case (mem_opcode)
                6'h28:   mem[mem_address[5:0]][7:0]  <= mem_write_data[7:0];
                6'h29:   mem[mem_address[5:0]][15:0] <= mem_write_data[15:0];
                default: mem[mem_address[5:0]]       <= mem_write_data;
            endcase
        end
    end
    assign mem_read_data    = mem[mem_address[5:0]];
    assign d4_mem_read_data = 32'h1357_9BDF + d4_mem_address;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          nbusy;
    } exp_t;

    exp_t exp_q[$];
    int   gcyc_q[$];
    int   gport_q[$];
    int   cyc = 0, done_cnt = 0, rv_total = 0;
    int   m_rd = 0, m_wr = 0, m_busy = 0;
    exp_t mon_e;
    int   mon_g, mon_gp;

    function automatic exp_t mk_exp(input int port, input logic we, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = err ? 1 : 1 + LAT;
        e.nrd   = (!we && !err) ? LAT + 1 : 0;
        e.nwr   = (we && !err) ? 1 : 0;
        e.nbusy = err ? 2 : LAT + 2;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: stamps grants, pops expectations on each rvalid
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_gnt && p1_gnt) chk("single_gnt", 2, 1);
            if (p0_gnt || p1_gnt) begin
                gcyc_q.push_back(cyc + 1);
                gport_q.push_back(p1_gnt ? 1 : 0);
                m_rd = 0; m_wr = 0; m_busy = 0;
            end
            m_rd   += int'(sig_mem_read);
            m_wr   += int'(sig_mem_write);
            m_busy += int'(busy);
            if (p0_rvalid || p1_rvalid) begin
                rv_total++;
                if (exp_q.size() == 0 || gcyc_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_g  = gcyc_q.pop_front();
                    mon_gp = gport_q.pop_front();
                    chk("gnt_port", mon_gp, mon_e.port);
                    chk("rvalid_port", {p1_rvalid, p0_rvalid}, (mon_e.port == 1) ? 2'b10 : 2'b01);
                    chk("rdata", (mon_e.port == 1) ? p1_rdata : p0_rdata, mon_e.rdata);
                    chk("err", (mon_e.port == 1) ? p1_err : p0_err, mon_e.err);
                    chk("latency", cyc + 1 - mon_g, mon_e.lat);
                    chk("idle_port_quiet", (mon_e.port == 1) ? {p0_err, p0_rdata} : {p1_err, p1_rdata}, 0);
                    chk("read_strobe_cycles", m_rd, mon_e.nrd);
                    chk("write_strobe_cycles", m_wr, mon_e.nwr);
                    chk("busy_cycles", m_busy, mon_e.nbusy);
                    done_cnt++;
                end
            end
        end
    end

    task automatic drive_port(input int port, input logic req, input logic we, input logic [5:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_opcode = op; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_opcode = op; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic wait_gnt(input int port, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); #1;
            if ((port == 0) ? p0_gnt : p1_gnt) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 60 && done_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        chk("completion_seen", done_cnt >= target, 1);
    endtask

    task automatic issue(input int port, input logic we, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        bit ok;
        int target;
        exp_q.push_back(mk_exp(port, we, exp_rdata, exp_err));
        target = done_cnt + 1;
        drive_port(port, 1'b1, we, op, addr, wdata);
        wait_gnt(port, ok);
        chk("gnt_seen", ok, 1);
        drive_port(port, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        wait_done(target);
    endtask

    task automatic port_seq(input int port, input logic [31:0] a0, input logic [31:0] a1);
        bit ok;
        for (int j = 0; j < 2; j++) begin
            drive_port(port, 1'b1, 1'b0, 6'h23, (j == 0) ? a0 : a1, 32'd0);
            wait_gnt(port, ok);
            chk("pending_gnt_seen", ok, 1);
        end
        drive_port(port, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit ok;
        int target, rv_before, g, rv, nrd, nbusy;
        logic [31:0] d4_data;

        vecs[0]  = '{0, 1'b1, 6'h2B, 32'd5,          32'hDEADBEEF, 32'd0,        1'b0};
        vecs[1]  = '{0, 1'b0, 6'h23, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{0, 1'b1, 6'h28, 32'd5,          32'h00000011, 32'd0,        1'b0};
        vecs[3]  = '{0, 1'b0, 6'h23, 32'd5,          32'd0,        32'hDEADBE11, 1'b0};
        vecs[4]  = '{0, 1'b1, 6'h29, 32'd5,          32'h00002222, 32'd0,        1'b0};
        vecs[5]  = '{0, 1'b0, 6'h23, 32'd5,          32'd0,        32'hDEAD2222, 1'b0};
        vecs[6]  = '{1, 1'b0, 6'h23, 32'd64,         32'd0,        32'd0,        1'b1};
        vecs[7]  = '{1, 1'b1, 6'h2B, 32'd63,         32'h12345678, 32'd0,        1'b0};
        vecs[8]  = '{1, 1'b0, 6'h23, 32'd63,         32'd0,        32'h12345678, 1'b0};
        vecs[9]  = '{0, 1'b0, 6'h23, 32'hFFFFFFFF,   32'd0,        32'd0,        1'b1};
        vecs[10] = '{1, 1'b1, 6'h2B, 32'd0,          32'hCAFEF00D, 32'd0,        1'b0};
        vecs[11] = '{0, 1'b0, 6'h23, 32'd0,          32'd0,        32'hCAFEF00D, 1'b0};
        vecs[12] = '{1, 1'b1, 6'h2B, 32'h40000005,   32'h0BADF00D, 32'd0,        1'b1};

        rst_n = 1'b0; mem_clear = 1'b1;
        drive_port(0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        drive_port(1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        d4_p0_req = 1'b0; d4_p0_addr = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {busy, sig_mem_read, sig_mem_write, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
        chk("reset_buses", mem_address | mem_write_data | {26'd0, mem_opcode} | p0_rdata | p1_rdata, 0);
        chk("reset_dut4", {d4_busy, d4_rd, d4_wr, d4_p0_gnt, d4_p0_rvalid, d4_p1_gnt, d4_p1_rvalid}, 0);
        mem_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].port, vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Both ports request continuously for two loads each
`ifdef DMEM_ARB_RR_EN
        exp_q.push_back(mk_exp(0, 1'b0, 32'hDEAD2222, 1'b0));
        exp_q.push_back(mk_exp(1, 1'b0, 32'h12345678, 1'b0));
        exp_q.push_back(mk_exp(0, 1'b0, 32'hCAFEF00D, 1'b0));
        exp_q.push_back(mk_exp(1, 1'b0, 32'hCAFEF00D, 1'b0));
`else
        exp_q.push_back(mk_exp(0, 1'b0, 32'hDEAD2222, 1'b0));
        exp_q.push_back(mk_exp(0, 1'b0, 32'hCAFEF00D, 1'b0));
        exp_q.push_back(mk_exp(1, 1'b0, 32'h12345678, 1'b0));
        exp_q.push_back(mk_exp(1, 1'b0, 32'hCAFEF00D, 1'b0));
`endif
        target = done_cnt + 4;
        fork
            port_seq(0, 32'd5, 32'd0);
            port_seq(1, 32'd63, 32'd0);
        join
        wait_done(target);

        // Reset asserted during WAIT of a load: transaction is dropped
        drive_port(0, 1'b1, 1'b0, 6'h23, 32'd5, 32'd0);
        wait_gnt(0, ok);
        chk("abort_gnt_seen", ok, 1);
        drive_port(0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        rv_before = rv_total;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl_zero", {busy, sig_mem_read, sig_mem_write, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
        chk("abort_buses_zero", mem_address | mem_write_data | {26'd0, mem_opcode} | p0_rdata | p1_rdata, 0);
        gcyc_q.delete();
        gport_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("no_rvalid_after_reset", rv_total, rv_before);
        issue(0, 1'b0, 6'h23, 32'd5, 32'd0, 32'hDEAD2222, 1'b0);

        // LATENCY=4 instance: load of address 0
        g = -1; rv = -1; nrd = 0; nbusy = 0; d4_data = 32'd0;
        d4_p0_addr = 32'd0;
        d4_p0_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (d4_p0_gnt) begin
                g = i;
                d4_p0_req = 1'b0;
            end
            nrd   += int'(d4_rd);
            nbusy += int'(d4_busy);
            if (d4_p0_rvalid) begin
                rv = i;
                d4_data = d4_p0_rdata;
            end
            if (d4_p1_rvalid || d4_p1_gnt) chk("lat4_port1_quiet", 1, 0);
        end
        chk("lat4_gnt_first_cycle", g, 0);
        chk("lat4_rvalid_offset", rv - g, 5);
        chk("lat4_read_cycles", nrd, 5);
        chk("lat4_busy_cycles", nbusy, 6);
        chk("lat4_rdata", d4_data, 32'h13579BDF);
        chk("lat4_err", d4_p0_err, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
